// File: rtl/ysyx_24120013_pkg.sv
// Shared constants for the ysyx_24120013 core controller: FSM state encodings
// and a helper that identifies states waiting on an external handshake.
package ysyx_24120013_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_INST = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_MEM_REQ   = 3'd4;
  localparam logic [2:0] S_MEM_WAIT  = 3'd5;
  localparam logic [2:0] S_WB        = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  // States in which progress depends on the IFU or LSU answering.
  function automatic logic is_wait_state(input logic [2:0] s);
    return (s == S_FETCH) || (s == S_WAIT_INST) || (s == S_MEM_REQ) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_24120013_watchdog.sv
// Stall watchdog: counts consecutive busy cycles without handshake progress
// and raises trip on the TIMEOUT_CYC-th such cycle.
module ysyx_24120013_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic clear,
  output logic trip
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Leaving a busy state always goes through a handshake or a non-busy state,
  // so clearing on !busy or clear also covers every state change.
  always_ff @(posedge clk) begin
    if (rst || !busy || clear) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign trip = busy && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ysyx_24120013_ctrl.sv
// Multi-cycle core controller FSM (fetch / exec / mem / writeback / halt).
// Optional stall watchdog enabled by defining YSYX_24120013_WATCHDOG_EN.
module ysyx_24120013_ctrl
  import ysyx_24120013_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  output logic        inst_latch_en,
  input  logic        idu_is_load,
  input  logic        idu_is_store,
  input  logic        idu_is_ebreak,
  input  logic        idu_rd_wen,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_wen,
  output logic        pc_we,
  output logic        commit,
  output logic [31:0] inst_cnt,
  output logic        halt,
  output logic        err,
  output logic [2:0]  state
);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] inst_cnt_q;
  logic        err_q;
  logic        hs;
  logic        trip;
  logic        live;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    hs = 1'b0;
    case (state_q)
      S_FETCH:     hs = ifu_req_ready;
      S_WAIT_INST: hs = ifu_rsp_valid;
      S_MEM_REQ:   hs = lsu_req_ready;
      S_MEM_WAIT:  hs = lsu_rsp_valid;
      default:     hs = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (hs) state_d = S_WAIT_INST;
      S_WAIT_INST: if (hs) state_d = S_EXEC;
      S_EXEC: begin
        if (idu_is_ebreak)                   state_d = S_HALT;
        else if (idu_is_load || idu_is_store) state_d = S_MEM_REQ;
        else                                 state_d = S_WB;
      end
      S_MEM_REQ:   if (hs) state_d = S_MEM_WAIT;
      S_MEM_WAIT:  if (hs) state_d = S_WB;
      S_WB:        state_d = S_FETCH;
      default:     state_d = S_HALT;
    endcase
    if (trip) state_d = S_HALT;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inst_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WB) inst_cnt_q <= inst_cnt_q + 32'd1;
    end
  end

`ifdef YSYX_24120013_WATCHDOG_EN
  ysyx_24120013_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .busy  (is_wait_state(state_q)),
    .clear (hs),
    .trip  (trip)
  );

  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (trip) err_q <= 1'b1;
  end
`else
  assign trip  = 1'b0;
  assign err_q = 1'b0;
`endif

  // Reset masks every output immediately, before the synchronous clear lands.
  assign live          = !rst;
  assign ifu_req_valid = live && (state_q == S_FETCH);
  assign inst_latch_en = live && (state_q == S_WAIT_INST) && ifu_rsp_valid;
  assign lsu_req_valid = live && (state_q == S_MEM_REQ);
  assign pc_we         = live && (state_q == S_WB);
  assign commit        = live && (state_q == S_WB);
  assign rf_wen        = live && (state_q == S_WB) && idu_rd_wen && !idu_is_store;
  assign halt          = live && (state_q == S_HALT);
  assign err           = live && err_q;
  assign state         = live ? state_q : S_IDLE;
  assign inst_cnt      = live ? inst_cnt_q : 32'd0;

endmodule

// File: tb/tb_ysyx_24120013_ctrl.sv
// Self-checking bench for ysyx_24120013_ctrl: per-cycle model comparison plus
// literal checks of traces, strobe counts and counter values.
module tb_ysyx_24120013_ctrl;
  import ysyx_24120013_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, inst_latch_en;
  logic        idu_is_load, idu_is_store, idu_is_ebreak, idu_rd_wen;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic        rf_wen, pc_we, commit, halt, err;
  logic [31:0] inst_cnt;
  logic [2:0]  state;

  ysyx_24120013_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .inst_latch_en(inst_latch_en),
    .idu_is_load(idu_is_load), .idu_is_store(idu_is_store),
    .idu_is_ebreak(idu_is_ebreak), .idu_rd_wen(idu_rd_wen),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .rf_wen(rf_wen), .pc_we(pc_we),
    .commit(commit), .inst_cnt(inst_cnt), .halt(halt), .err(err),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbers follow the published state codes; the model advances one
  // clock at a time from the handshake rules.
  int          m_st = 0;
  logic [31:0] m_cnt = '0;
  bit          m_err = 1'b0;
  int          m_stall = 0;
  bit          preset_req = 1'b0;
  int          nx;

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_cnt <= '0; m_err <= 1'b0; m_stall <= 0;
    end else begin
      nx = m_st;
      case (m_st)
        0: nx = 1;
        1: if (ifu_req_ready) nx = 2;
        2: if (ifu_rsp_valid) nx = 3;
        3: nx = idu_is_ebreak ? 7 : ((idu_is_load || idu_is_store) ? 4 : 6);
        4: if (lsu_req_ready) nx = 5;
        5: if (lsu_rsp_valid) nx = 6;
        6: nx = 1;
        default: nx = 7;
      endcase
      if (m_st == 6) m_cnt <= m_cnt + 1;
`ifdef YSYX_24120013_WATCHDOG_EN
      if ((m_st == 1 || m_st == 2 || m_st == 4 || m_st == 5) && nx == m_st) begin
        if (m_stall + 1 == T) begin
          nx = 7; m_err <= 1'b1; m_stall <= 0;
        end else m_stall <= m_stall + 1;
      end else m_stall <= 0;
`endif
      m_st <= nx;
      if (preset_req) m_cnt <= 32'hFFFF_FFFF;
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  bit armed = 1'b0;
  int n_commit = 0, n_rfwen = 0, n_pcwe = 0, n_lsuv = 0, n_fetchv = 0, n_strobe = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("state",         32'(state),         rst ? 32'd0 : 32'(m_st));
      check("inst_cnt",      inst_cnt,           rst ? 32'd0 : m_cnt);
      check("ifu_req_valid", 32'(ifu_req_valid), 32'(!rst && m_st == 1));
      check("inst_latch_en", 32'(inst_latch_en), 32'(!rst && m_st == 2 && ifu_rsp_valid));
      check("lsu_req_valid", 32'(lsu_req_valid), 32'(!rst && m_st == 4));
      check("pc_we",         32'(pc_we),         32'(!rst && m_st == 6));
      check("commit",        32'(commit),        32'(!rst && m_st == 6));
      check("rf_wen",        32'(rf_wen),        32'(!rst && m_st == 6 && idu_rd_wen && !idu_is_store));
      check("halt",          32'(halt),          32'(!rst && m_st == 7));
      check("err",           32'(err),           32'(!rst && m_err));
      n_commit += int'(commit);
      n_rfwen  += int'(rf_wen);
      n_pcwe   += int'(pc_we);
      n_lsuv   += int'(lsu_req_valid);
      n_fetchv += int'(ifu_req_valid);
      n_strobe += int'(ifu_req_valid) + int'(inst_latch_en) + int'(lsu_req_valid)
                + int'(rf_wen) + int'(pc_we) + int'(commit);
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0] trace [$];

  task automatic clear_inputs();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
  endtask

  // Drives one instruction from FETCH to its next FETCH (or HALT); called at posedge+1.
  task automatic run_inst(input bit ld, input bit st, input bit eb, input bit rdw, input int lsu_wait);
    int k = 0;
    bit seen_wb = 1'b0;
    trace.delete();
    idu_is_load = ld; idu_is_store = st; idu_is_ebreak = eb; idu_rd_wen = rdw;
    for (int c = 0; c < 40; c++) begin
      trace.push_back(state);
      ifu_req_ready = (state == S_FETCH);
      ifu_rsp_valid = (state == S_WAIT_INST);
      lsu_req_ready = (state == S_MEM_REQ) && (k >= lsu_wait);
      lsu_rsp_valid = (state == S_MEM_WAIT);
      if (state == S_MEM_REQ) k++;
      if (state == S_WB) seen_wb = 1'b1;
      if ((seen_wb && state == S_FETCH) || state == S_HALT) begin
        clear_inputs();
        return;
      end
      @(posedge clk); #1;
    end
    check("run_inst_budget", 32'd1, 32'd0);
    clear_inputs();
  endtask

  task automatic check_trace(input string name, input logic [2:0] exp [$]);
    check({name, "_len"}, 32'(trace.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      check(name, 32'(trace[i]), 32'(exp[i]));
  endtask

  initial begin
    int c0, r0, p0, l0, s0, f0;
    rst = 1'b1;
    clear_inputs();
    idu_is_load = 0; idu_is_store = 0; idu_is_ebreak = 0; idu_rd_wen = 0;
    @(posedge clk); #1;
    armed = 1'b1;
    @(posedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", inst_cnt, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_ifu_valid", 32'(ifu_req_valid), 32'd0);

    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_to_fetch", 32'(state), 32'(S_FETCH));

    // ALU, rd_wen=1: 1,2,3,6,1 and one retire
    c0 = n_commit; r0 = n_rfwen; p0 = n_pcwe;
    run_inst(0, 0, 0, 1, 0);
    check_trace("alu_trace", '{3'd1, 3'd2, 3'd3, 3'd6, 3'd1});
    check("alu_commits", 32'(n_commit - c0), 32'd1);
    check("alu_rfwen", 32'(n_rfwen - r0), 32'd1);
    check("alu_pcwe", 32'(n_pcwe - p0), 32'd1);
    check("alu_cnt", inst_cnt, 32'd1);

    // Load, lsu ready low 3 cycles: 4 cycles of lsu_req_valid
    c0 = n_commit; r0 = n_rfwen; l0 = n_lsuv;
    run_inst(1, 0, 0, 1, 3);
    check_trace("ld_trace", '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd6, 3'd1});
    check("ld_lsu_valid_cycles", 32'(n_lsuv - l0), 32'd4);
    check("ld_commits", 32'(n_commit - c0), 32'd1);
    check("ld_rfwen", 32'(n_rfwen - r0), 32'd1);
    check("ld_cnt", inst_cnt, 32'd2);

    // Store with rd_wen=1: no register write
    c0 = n_commit; r0 = n_rfwen; p0 = n_pcwe;
    run_inst(0, 1, 0, 1, 0);
    check("st_rfwen", 32'(n_rfwen - r0), 32'd0);
    check("st_pcwe", 32'(n_pcwe - p0), 32'd1);
    check("st_commits", 32'(n_commit - c0), 32'd1);

    // ALU with rd_wen=0
    r0 = n_rfwen;
    run_inst(0, 0, 0, 0, 0);
    check("alu_nowb_rfwen", 32'(n_rfwen - r0), 32'd0);
    check("alu_nowb_cnt", inst_cnt, 32'd4);

    // Counter wrap: preset all ones, retire one ALU
    @(negedge clk); #1;
    force dut.inst_cnt_q = 32'hFFFF_FFFF;
    preset_req = 1'b1;
    @(posedge clk); #1;
    release dut.inst_cnt_q;
    preset_req = 1'b0;
    check("wrap_preset", inst_cnt, 32'hFFFF_FFFF);
    run_inst(0, 0, 0, 1, 0);
    check("wrap_cnt", inst_cnt, 32'd0);

    // ebreak -> sticky HALT, late inputs ignored
    run_inst(0, 0, 1, 0, 0);
    check("eb_state", 32'(state), 32'(S_HALT));
    check("eb_halt", 32'(halt), 32'd1);
    s0 = n_strobe;
    for (int i = 0; i < 4; i++) begin
      ifu_rsp_valid = i[0]; ifu_req_ready = 1'b1;
      lsu_req_ready = 1'b1; lsu_rsp_valid = !i[0];
      @(posedge clk); #1;
    end
    clear_inputs();
    check("halt_no_strobes", 32'(n_strobe - s0), 32'd0);
    check("halt_sticky", 32'(state), 32'(S_HALT));
    rst = 1'b1;
    @(posedge clk); #1;
    check("halt_rst_state", 32'(state), 32'd0);
    check("halt_rst_cnt", inst_cnt, 32'd0);
    check("halt_rst_halt", 32'(halt), 32'd0);

    // Late response after reset ignored; reset mid-handshake
    rst = 1'b0;
    @(posedge clk); #1;
    ifu_rsp_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifu_rsp_valid = 1'b0;
    check("late_rsp_ignored", 32'(state), 32'(S_FETCH));
    ifu_req_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    ifu_req_ready = 1'b0;
    check("mid_hs_rst", 32'(state), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("refetch", 32'(state), 32'(S_FETCH));

    // Fetch stall: watchdog trip or indefinite wait
    f0 = n_fetchv;
    repeat (20) begin @(posedge clk); #1; end
`ifdef YSYX_24120013_WATCHDOG_EN
    check("wd_state", 32'(state), 32'(S_HALT));
    check("wd_err", 32'(err), 32'd1);
    check("wd_fetch_cycles", 32'(n_fetchv - f0), 32'd8);
`else
    check("nowd_state", 32'(state), 32'(S_FETCH));
    check("nowd_err", 32'(err), 32'd0);
    check("nowd_fetch_cycles", 32'(n_fetchv - f0), 32'd20);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    check("err_cleared", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    armed = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
